// File: rtl/m_user_input_cond.sv
// m_user_input_cond: raw buttons -> synchronised, debounced, one-hot single-cycle command pulses.
// Optional AUTO_REPEAT_EN macro adds hold-to-repeat on INC and DEC.
module m_user_input_cond #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 15000000
) (
  input  logic       w_clk,
  input  logic       w_rst,
  input  logic [3:0] i_btn_raw,
  output logic [3:0] o_user_input,
  output logic [3:0] o_btn_held
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("m_user_input_cond: illegal parameter value");
  end
  logic [3:0]    r_sync1, r_sync2, r_stable, r_prev, r_pending;
  logic [3:0]    w_set, w_grant;
  logic [CW-1:0] r_cnt [4];
  assign o_btn_held = r_stable;
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_prev       <= '0;
      r_pending    <= '0;
      o_user_input <= '0;
    end else begin
      r_sync1      <= i_btn_raw;
      r_sync2      <= r_sync1;
      r_prev       <= r_stable;
      r_pending    <= (r_pending | w_set) & ~w_grant;
      o_user_input <= w_grant;
    end
  end
  // a sample matching the stable level (a bounce) restarts the count
  always_ff @(posedge w_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_rst || r_sync2[b] == r_stable[b]) begin
        r_cnt[b] <= '0;
        if (w_rst) r_stable[b] <= 1'b0;
      end else if (r_cnt[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_stable[b] <= r_sync2[b];
        r_cnt[b]    <= '0;
      end else begin
        r_cnt[b] <= r_cnt[b] + CW'(1);
      end
    end
  end
  // priority OK > DEC > INC > AUX
  always_comb
    w_grant = r_pending[2] ? 4'b0100 :
              r_pending[1] ? 4'b0010 :
              r_pending[0] ? 4'b0001 :
              r_pending[3] ? 4'b1000 : 4'b0000;
`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] r_rep_cnt [2];
  logic [1:0]    r_rep_first, w_rep;
  always_comb begin
    w_rep = '0;
    for (int b = 0; b < 2; b++)
      w_rep[b] = r_stable[b] &&
                 r_rep_cnt[b] == (r_rep_first[b] ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD));
  end
  // counter holds cycles spent held since the last (re)load; reload to 1 keeps the period exact
  always_ff @(posedge w_clk) begin
    for (int b = 0; b < 2; b++) begin
      if (w_rst || !r_stable[b]) begin
        r_rep_cnt[b]   <= '0;
        r_rep_first[b] <= 1'b1;
      end else if (w_rep[b]) begin
        r_rep_cnt[b]   <= RW'(1);
        r_rep_first[b] <= 1'b0;
      end else begin
        r_rep_cnt[b] <= r_rep_cnt[b] + RW'(1);
      end
    end
  end
  assign w_set = (r_stable & ~r_prev) | {2'b00, w_rep};
`else
  assign w_set = r_stable & ~r_prev;
`endif
endmodule
